mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Sequencing and arbitration controller for the 4-byte `memory_storage` array. Accepts byte read/write requests from two requesters, grants one at a time, and drives the array's `data`/`store`/`adder` inputs with a setup–strobe–hold sequence so the level-sensitive byte storage captures cleanly. Read data is sampled from the array's `memory` output and returned registered. Sits between the top-level input/display logic and `memory_storage`.

## Interface
- `STROBE_CYCLES`, 1: width of the `mem_store` pulse in clock cycles; legal range 1..15.

- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req0`  in  1  requester 0 access request; hold high until `gnt0`
- `we0`  in  1  requester 0: 1 = write, 0 = read; sampled with `req0`
- `addr0`  in  2  requester 0 byte address
- `wdata0`  in  8  requester 0 write data
- `gnt0`  out  1  one-cycle grant pulse to requester 0
- `done0`  out  1  one-cycle completion pulse to requester 0
- `req1`, `we1`, `addr1`, `wdata1`, `gnt1`, `done1`: same as requester 0, for requester 1
- `rdata`  out  8  registered read data; valid with `doneN` of a read, held until next read completes
- `busy`  out  1  high in every state except IDLE
- `mem_data`  out  8  to `memory_storage.data`
- `mem_store`  out  1  to `memory_storage.store`
- `mem_adder`  out  2  to `memory_storage.adder`
- `mem_memory`  in  8  from `memory_storage.memory`

## Operation
- States: IDLE, SETUP, STROBE, HOLD, SAMPLE, DONE.
- IDLE: if any `reqN` high, arbitrate, latch winner's `we`/`addr`/`wdata` and winner ID, go SETUP. No request: stay.
- SETUP (1 cycle): `gntN`=1 for winner; `mem_adder`/`mem_data` driven from latched values; `mem_store`=0. Next: STROBE if write, SAMPLE if read.
- STROBE (`STROBE_CYCLES` cycles, 4-bit down-counter): `mem_store`=1. Next: HOLD.
- HOLD (1 cycle): `mem_store`=0, address/data unchanged. Next: DONE.
- SAMPLE (1 cycle): `rdata` <= `mem_memory` at end of cycle. Next: DONE.
- DONE (1 cycle): `doneN`=1 for winner. Next: IDLE (new request not accepted until back in IDLE).
- `mem_adder`/`mem_data` change only on entry to SETUP; they hold their last values in IDLE, DONE, HOLD.
- `mem_store` never high outside STROBE; `gnt0`&`gnt1` and `done0`&`done1` never both high.
- Requester may drop `reqN` after `gntN`; a request dropped before grant is withdrawn with no effect. Requester changes to `we`/`addr`/`wdata` after the latch edge are ignored.
- Loser of arbitration keeps `req` high and is served next.

## Timing
- Edge E0 = IDLE edge sampling `reqN` high. Cycle after E0 = SETUP (`gntN`=1).
- Write: `mem_store` high cycles 2..1+S (S = `STROBE_CYCLES`), HOLD cycle S+2, `doneN` in cycle S+3. S=1: 4 cycles E0→done.
- Read: SAMPLE cycle 2, `doneN` and valid `rdata` cycle 3.
- Back-to-back: earliest next SETUP is 2 cycles after DONE (DONE→IDLE→SETUP).
- Reset (any time, incl. mid-transaction): state IDLE, `mem_store`=0 immediately, `mem_adder`=0, `mem_data`=0, `rdata`=0, `gnt0/1`=0, `done0/1`=0, `busy`=0, arbitration pointer set so requester 0 wins first tie; aborted transaction produces no `done`.

## Configuration
- `MEM_ACCESS_CTRL_RR_EN` defined: round-robin; on simultaneous requests the requester not granted last wins; single request always granted.
- Undefined: fixed priority; requester 0 always wins ties; pointer logic absent.

## Test plan
- Reset, req0 write addr 2 data 0xA5, S=1 → gnt0 cycle 1, mem_store high cycle 2 only with mem_adder=2, mem_data=0xA5; done0 cycle 4.
- req1 read addr 2 after above → done1 cycle 3 after sample edge, rdata=0xA5, mem_store stays 0.
- Write 0x11,0x22,0x33,0x44 to addr 0..3, read all back → rdata 0x11..0x44 in order; other bytes unchanged.
- req0 and req1 held high continuously, both writes → with RR_EN grants alternate 0,1,0,1; without, only requester 0 granted while req0 high.
- S=3 write → mem_store high exactly 3 cycles, mem_adder/mem_data stable from SETUP through HOLD.
- Assert reset during STROBE → mem_store low same cycle, no done, busy=0; next request completes normally.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Request/grant and memory-array bus between two requesters, mem_access_ctrl and memory_storage.
// The controller attaches through the slave modport; requesters and the array model use master.
interface mem_access_ctrl_if;
   logic       req0;
   logic       we0;
   logic [1:0] addr0;
   logic [7:0] wdata0;
   logic       gnt0;
   logic       done0;
   logic       req1;
   logic       we1;
   logic [1:0] addr1;
   logic [7:0] wdata1;
   logic       gnt1;
   logic       done1;
   logic [7:0] rdata;
   logic       busy;
   logic [7:0] mem_data;
   logic       mem_store;
   logic [1:0] mem_adder;
   logic [7:0] mem_memory;

   modport slave (
      input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_memory,
      output gnt0, done0, gnt1, done1, rdata, busy, mem_data, mem_store, mem_adder
   );

   modport master (
      output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_memory,
      input  gnt0, done0, gnt1, done1, rdata, busy, mem_data, mem_store, mem_adder
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Two-requester arbiter driving a level-sensitive byte array with setup/strobe/hold sequencing.
// Define MEM_ACCESS_CTRL_RR_EN for round-robin arbitration; default build uses fixed priority (requester 0).
module mem_access_ctrl #(
   parameter int STROBE_CYCLES = 1
) (
   input  logic            clk,
   input  logic            reset,
   mem_access_ctrl_if.slave bus
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SETUP  = 3'd1;
   localparam logic [2:0] ST_STROBE = 3'd2;
   localparam logic [2:0] ST_HOLD   = 3'd3;
   localparam logic [2:0] ST_SAMPLE = 3'd4;
   localparam logic [2:0] ST_DONE   = 3'd5;

   localparam logic [3:0] LP_STROBE_LAST = 4'(STROBE_CYCLES - 1);

   logic [2:0] r_state;
   logic       r_winId;
   logic       r_we;
   logic [1:0] r_addr;
   logic [7:0] r_wdata;
   logic [3:0] r_cnt;
   logic [7:0] r_rdata;

   logic w_anyReq;
   logic w_pick1;

   assign w_anyReq = bus.req0 | bus.req1;

`ifdef MEM_ACCESS_CTRL_RR_EN
   // r_prefer1 is set after requester 0 wins, so a tie goes to whoever was not served last
   logic r_prefer1;

   assign w_pick1 = bus.req1 & (~bus.req0 | r_prefer1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prefer1 <= 1'b0;
      end else if (r_state == ST_IDLE && w_anyReq) begin
         r_prefer1 <= ~w_pick1;
      end
   end
`else
   assign w_pick1 = bus.req1 & ~bus.req0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_winId <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= 2'd0;
         r_wdata <= 8'd0;
         r_cnt   <= 4'd0;
         r_rdata <= 8'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_anyReq) begin
                  r_winId <= w_pick1;
                  r_we    <= w_pick1 ? bus.we1    : bus.we0;
                  r_addr  <= w_pick1 ? bus.addr1  : bus.addr0;
                  r_wdata <= w_pick1 ? bus.wdata1 : bus.wdata0;
                  r_state <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (r_we) begin
                  r_cnt   <= LP_STROBE_LAST;
                  r_state <= ST_STROBE;
               end else begin
                  r_state <= ST_SAMPLE;
               end
            end
            ST_STROBE: begin
               if (r_cnt == 4'd0) begin
                  r_state <= ST_HOLD;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_HOLD: begin
               r_state <= ST_DONE;
            end
            ST_SAMPLE: begin
               r_rdata <= bus.mem_memory;
               r_state <= ST_DONE;
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Strobe decodes straight from state so an async reset drops it in the same cycle
   assign bus.mem_store = (r_state == ST_STROBE);
   assign bus.mem_adder = r_addr;
   assign bus.mem_data  = r_wdata;
   assign bus.rdata     = r_rdata;
   assign bus.busy      = (r_state != ST_IDLE);
   assign bus.gnt0      = (r_state == ST_SETUP) & ~r_winId;
   assign bus.gnt1      = (r_state == ST_SETUP) &  r_winId;
   assign bus.done0     = (r_state == ST_DONE)  & ~r_winId;
   assign bus.done1     = (r_state == ST_DONE)  &  r_winId;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomised bench for mem_access_ctrl against a transaction-timeline reference model.
// Also exercises a STROBE_CYCLES=3 instance for strobe width and address/data stability.
module tb_mem_access_ctrl;

   localparam int S  = 1;
   localparam int S3 = 3;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   mem_access_ctrl_if bus();
   mem_access_ctrl_if bus3();

   mem_access_ctrl #(.STROBE_CYCLES(S)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   mem_access_ctrl #(.STROBE_CYCLES(S3)) dut3 (
      .clk(clk),
      .reset(reset),
      .bus(bus3)
   );

   // Behavioural memory_storage: transparent byte latch while store is high
   logic [7:0] stor  [4] = '{default: 8'h00};
   logic [7:0] stor3 [4] = '{default: 8'h00};

   always @(bus.mem_store or bus.mem_adder or bus.mem_data) begin
      if (bus.mem_store) stor[bus.mem_adder] = bus.mem_data;
   end

   always @(bus3.mem_store or bus3.mem_adder or bus3.mem_data) begin
      if (bus3.mem_store) stor3[bus3.mem_adder] = bus3.mem_data;
   end

   assign bus.mem_memory  = stor[bus.mem_adder];
   assign bus3.mem_memory = stor3[bus3.mem_adder];

   int compared   = 0;
   int mismatched = 0;

   logic [7:0] refMem [4];
   int         tcur;
   int         doneT;
   logic       mWin;
   logic       mWe;
   logic [7:0] expData;
   logic [1:0] expAddr;
   logic [7:0] expRdata;
   logic [7:0] pendRdata;
   logic       lastGnt;

   logic       p     [2];
   logic       pWe   [2];
   logic [1:0] pAddr [2];
   logic [7:0] pData [2];
   bit         rearm;
   bit         randomMode;
   int         gntCount [2];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic newRequest(input int i, input bit forceWrite);
      p[i]     = 1'b1;
      pWe[i]   = forceWrite ? 1'b1 : 1'($urandom_range(0, 1));
      pAddr[i] = 2'($urandom_range(0, 3));
      pData[i] = 8'($urandom_range(0, 255));
   endtask

   task automatic driveInputs();
      bus.req0   = p[0];
      bus.we0    = p[0] ? pWe[0]   : 1'($urandom_range(0, 1));
      bus.addr0  = p[0] ? pAddr[0] : 2'($urandom_range(0, 3));
      bus.wdata0 = p[0] ? pData[0] : 8'($urandom_range(0, 255));
      bus.req1   = p[1];
      bus.we1    = p[1] ? pWe[1]   : 1'($urandom_range(0, 1));
      bus.addr1  = p[1] ? pAddr[1] : 2'($urandom_range(0, 3));
      bus.wdata1 = p[1] ? pData[1] : 8'($urandom_range(0, 255));
   endtask

   // Random traffic: new requests appear, ungranted ones are occasionally withdrawn
   task automatic applyStimulus();
      if (randomMode) begin
         for (int i = 0; i < 2; i++) begin
            if (!p[i] && $urandom_range(0, 3) == 0) newRequest(i, 1'b0);
            else if (p[i] && $urandom_range(0, 31) == 0) p[i] = 1'b0;
         end
      end
   endtask

   task automatic resetModel();
      tcur     = 0;
      doneT    = 0;
      mWin     = 1'b0;
      mWe      = 1'b0;
      expAddr  = 2'd0;
      expData  = 8'd0;
      expRdata = 8'd0;
      lastGnt  = 1'b1;
      p[0]     = 1'b0;
      p[1]     = 1'b0;
   endtask

   // One cycle: check what the timeline predicts for this cycle, then drive the next edge
   task automatic stepCycle();
      logic w;
      @(negedge clk);
      if (tcur != 0 && tcur == doneT && !mWe) expRdata = pendRdata;
      checkOutput("busy",  32'(bus.busy),  32'(tcur != 0));
      checkOutput("gnt0",  32'(bus.gnt0),  32'(tcur == 1 && !mWin));
      checkOutput("gnt1",  32'(bus.gnt1),  32'(tcur == 1 && mWin));
      checkOutput("done0", 32'(bus.done0), 32'(tcur != 0 && tcur == doneT && !mWin));
      checkOutput("done1", 32'(bus.done1), 32'(tcur != 0 && tcur == doneT && mWin));
      checkOutput("store", 32'(bus.mem_store), 32'(mWe && tcur >= 2 && tcur <= S + 1));
      checkOutput("adder", 32'(bus.mem_adder), 32'(expAddr));
      checkOutput("mdata", 32'(bus.mem_data),  32'(expData));
      checkOutput("rdata", 32'(bus.rdata),     32'(expRdata));
      if (tcur == 0) begin
         for (int k = 0; k < 4; k++)
            checkOutput($sformatf("mem%0d", k), 32'(stor[k]), 32'(refMem[k]));
      end
      if (tcur == 1) begin
         gntCount[mWin]++;
         if (rearm) newRequest(int'(mWin), 1'b1);
         else p[mWin] = 1'b0;
      end
      applyStimulus();
      driveInputs();
      if (tcur == 0) begin
         if (p[0] || p[1]) begin
`ifdef MEM_ACCESS_CTRL_RR_EN
            w = (p[0] && p[1]) ? ~lastGnt : p[1];
`else
            w = p[1] && !p[0];
`endif
            lastGnt = w;
            mWin    = w;
            mWe     = pWe[w];
            expAddr = pAddr[w];
            expData = pData[w];
            doneT   = mWe ? S + 3 : 3;
            if (mWe) refMem[expAddr] = expData;
            else pendRdata = refMem[expAddr];
            tcur = 1;
         end
      end else if (tcur == doneT) begin
         tcur = 0;
      end else begin
         tcur++;
      end
   endtask

   task automatic runUntilIdle(input int budget);
      int n = 0;
      while ((tcur != 0 || p[0] || p[1]) && n < budget) begin
         stepCycle();
         n++;
      end
      checkOutput("drainTimeout", 32'(tcur != 0 || p[0] || p[1]), 32'd0);
      stepCycle();
   endtask

   task automatic request(input int i, input bit we, input logic [1:0] a, input logic [7:0] d);
      p[i] = 1'b1; pWe[i] = we; pAddr[i] = a; pData[i] = d;
   endtask

   initial begin
      int c0, c1, d, n, storeCnt, gntCyc, doneCyc;
      reset = 1'b1;
      rearm = 1'b0;
      randomMode = 1'b0;
      gntCount[0] = 0;
      gntCount[1] = 0;
      for (int k = 0; k < 4; k++) refMem[k] = 8'h00;
      resetModel();
      driveInputs();
      bus3.req0 = 1'b0; bus3.we0 = 1'b0; bus3.addr0 = 2'd0; bus3.wdata0 = 8'd0;
      bus3.req1 = 1'b0; bus3.we1 = 1'b0; bus3.addr1 = 2'd0; bus3.wdata1 = 8'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      stepCycle();

      request(0, 1'b1, 2'd2, 8'hA5);
      runUntilIdle(20);
      request(1, 1'b0, 2'd2, 8'h00);
      runUntilIdle(20);

      for (int a = 0; a < 4; a++) begin
         request(0, 1'b1, 2'(a), 8'(8'h11 * (a + 1)));
         runUntilIdle(20);
      end
      for (int a = 0; a < 4; a++) begin
         request(a % 2, 1'b0, 2'(a), 8'h00);
         runUntilIdle(20);
      end

      // Both requesters hammering with writes: arbitration fairness window
      c0 = gntCount[0];
      c1 = gntCount[1];
      rearm = 1'b1;
      newRequest(0, 1'b1);
      newRequest(1, 1'b1);
      repeat (40) stepCycle();
      c0 = gntCount[0] - c0;
      c1 = gntCount[1] - c1;
      rearm = 1'b0;
`ifdef MEM_ACCESS_CTRL_RR_EN
      d = c0 - c1;
      checkOutput("rrBalance", 32'(d >= -1 && d <= 1 && c1 > 0), 32'd1);
`else
      checkOutput("fixedNoGnt1", 32'(c1), 32'd0);
`endif
      runUntilIdle(40);

      randomMode = 1'b1;
      repeat (1500) stepCycle();
      randomMode = 1'b0;
      runUntilIdle(60);

      // Abort a write mid-strobe; data equals current contents so the array stays predictable
      request(0, 1'b1, 2'd3, refMem[3]);
      n = 0;
      while (tcur != 2 && n < 10) begin
         stepCycle();
         n++;
      end
      checkOutput("reachStrobe", 32'(tcur), 32'd2);
      @(posedge clk);
      #2;
      checkOutput("storeBeforeReset", 32'(bus.mem_store), 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("rstStore", 32'(bus.mem_store), 32'd0);
      checkOutput("rstBusy",  32'(bus.busy),      32'd0);
      checkOutput("rstDone0", 32'(bus.done0),     32'd0);
      checkOutput("rstAdder", 32'(bus.mem_adder), 32'd0);
      resetModel();
      driveInputs();
      @(negedge clk);
      reset = 1'b0;
      stepCycle();
      stepCycle();
      request(1, 1'b1, 2'd1, 8'h5A);
      runUntilIdle(20);
      request(0, 1'b0, 2'd1, 8'h00);
      runUntilIdle(20);

      // Wide-strobe instance: inputs scrambled after grant must not disturb the bus
      storeCnt = 0;
      gntCyc   = -1;
      doneCyc  = -1;
      bus3.req0 = 1'b1; bus3.we0 = 1'b1; bus3.addr0 = 2'd1; bus3.wdata0 = 8'h3C;
      for (int cy = 1; cy <= 20 && doneCyc < 0; cy++) begin
         @(negedge clk);
         checkOutput($sformatf("s3store%0d", cy), 32'(bus3.mem_store), 32'(cy >= 2 && cy <= S3 + 1));
         if (bus3.mem_store) storeCnt++;
         if (bus3.gnt0) begin
            gntCyc = cy;
            bus3.req0 = 1'b0; bus3.addr0 = 2'd3; bus3.wdata0 = 8'hFF;
         end
         if (gntCyc > 0) begin
            checkOutput("s3adder", 32'(bus3.mem_adder), 32'd1);
            checkOutput("s3data",  32'(bus3.mem_data),  32'h3C);
         end
         if (bus3.done0) doneCyc = cy;
      end
      checkOutput("s3gntCycle",  32'(gntCyc),   32'd1);
      checkOutput("s3doneCycle", 32'(doneCyc),  32'(S3 + 3));
      checkOutput("s3storeCnt",  32'(storeCnt), 32'(S3));
      checkOutput("s3mem1",      32'(stor3[1]), 32'h3C);
      checkOutput("s3mem3",      32'(stor3[3]), 32'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
